wb_port_arbiter: RTL



---
 rtl/wisc_pkg.sv | 16 +
 rtl/wb_pend_fifo.sv | 62 ++++++
 rtl/wb_port_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/wisc_pkg.sv
// Shared widths and the pending-write entry format for the writeback path.
package wisc_pkg;
  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction
endpackage

// File: rtl/wb_pend_fifo.sv
// Circular queue of late load returns; entries can be squashed in place by address.
module wb_pend_fifo
  import wisc_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  input  logic                         squash_en,
  input  logic [REG_AW-1:0]            squash_dst,
  output wb_entry_t                    head_entry,
  output logic [CW-1:0]                count,
  output logic [DEPTH-1:0]             ent_vld,
  output logic [DEPTH-1:0][REG_AW-1:0] ent_dst
);
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [PW-1:0]                head, tail;

  // Popped slots drop their valid bit so ent_vld reflects only live entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld  <= '0;
      ent_dst  <= '0;
      ent_data <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && tail == PW'(i)) begin
          ent_vld[i]  <= push_entry.vld;
          ent_dst[i]  <= push_entry.dst;
          ent_data[i] <= push_entry.data;
        end else if (pop && head == PW'(i)) begin
          ent_vld[i] <= 1'b0;
        end else if (squash_en && ent_dst[i] == squash_dst) begin
          ent_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + PW'(1);
      if (push) tail <= tail + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_entry = '{vld: ent_vld[head], dst: ent_dst[head], data: ent_data[head]};
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between writeback and buffered late load returns.
module wb_port_arbiter
  import wisc_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_dst,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic [NUM_REGS-1:0] pend_mask
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  wb_entry_t                    head_entry, push_entry;
  logic [CW-1:0]                count;
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][REG_AW-1:0] ent_dst;
  logic                         pipe_go, pop, push, q_empty;
  logic [WW-1:0]                wait_cnt, wait_nxt;

  assign q_empty   = (count == '0);
  assign mem_ready = (count < CW'(DEPTH));
  assign pipe_go   = pipe_we && !pipe_stall;
  assign pop       = !pipe_go && !q_empty;
  assign push      = mem_valid && mem_ready;

  // A same-cycle pipe write to the same register is younger, so the return lands dead.
  assign push_entry = '{vld: !(pipe_go && pipe_dst == mem_dst), dst: mem_dst, data: mem_data};

  wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .squash_en  (pipe_go),
    .squash_dst (pipe_dst),
    .head_entry (head_entry),
    .count      (count),
    .ent_vld    (ent_vld),
    .ent_dst    (ent_dst)
  );

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    if (pipe_go) begin
      rf_we   = 1'b1;
      rf_addr = pipe_dst;
      rf_data = pipe_data;
    end else if (pop && head_entry.vld) begin
      rf_we   = 1'b1;
      rf_addr = head_entry.dst;
      rf_data = head_entry.data;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i]) pend_mask = pend_mask | reg_onehot(ent_dst[i]);
  end

  // Only a live head accrues wait; a squashed head holds the count until it drains.
  always_comb begin
    wait_nxt = wait_cnt;
    if (q_empty || pop)
      wait_nxt = '0;
    else if (head_entry.vld && wait_cnt != WW'(MAX_WAIT))
      wait_nxt = wait_cnt + WW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= '0;
      pipe_stall <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (pop)
        pipe_stall <= 1'b0;
      else if (wait_nxt == WW'(MAX_WAIT))
        pipe_stall <= 1'b1;
    end
  end
endmodule
